// File: rtl/tdm_demux_rx.sv
// Serial TDM receiver: demultiplexes one bit per valid cycle into NUM_CH channel
// registers and offers each completed frame on a single-entry valid/ready buffer.
module tdm_demux_rx #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     in_bit,
    input  logic                     in_sof,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH*CH_W-1:0]   out_data,
    output logic                     sync_err,
    output logic                     overflow
);
    localparam int FRAME_BITS = NUM_CH * CH_W;
    localparam int CNT_W      = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

    typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [FRAME_BITS-1:0]   shadow_q, shadow_d;
    logic                    out_valid_q, out_valid_d;
    logic [FRAME_BITS-1:0]   out_data_q, out_data_d;
    logic                    sync_err_q, sync_err_d;
    logic                    overflow_q, overflow_d;

    logic                    store;
    logic                    clr;
    logic                    last;
    logic [CNT_W-1:0]        wr_idx;
    logic [FRAME_BITS-1:0]   hit;

    // Frame bit gi lands MSB-first inside channel gi/CH_W.
    for (genvar gi = 0; gi < FRAME_BITS; gi++) begin : g_bit
        localparam int POS = (gi / CH_W) * CH_W + (CH_W - 1 - (gi % CH_W));
        assign hit[gi]       = store && (wr_idx == CNT_W'(gi));
        assign shadow_d[POS] = hit[gi] ? in_bit : (clr ? 1'b0 : shadow_q[POS]);
    end

    always_comb begin
        store       = in_valid && (in_sof || (state_q == RECV));
        clr         = in_valid && in_sof;
        wr_idx      = in_sof ? '0 : cnt_q;
        last        = store && (wr_idx == CNT_W'(FRAME_BITS - 1));

        state_d     = state_q;
        cnt_d       = cnt_q;
        if (store) begin
            if (last) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                state_d = RECV;
                cnt_d   = wr_idx + CNT_W'(1);
            end
        end

        sync_err_d  = in_valid && in_sof && (state_q == RECV);

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        overflow_d  = 1'b0;
        if (last) begin
            if (!out_valid_q || out_ready) begin
                out_valid_d = 1'b1;
                out_data_d  = shadow_d;
            end else begin
                overflow_d  = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shadow_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sync_err_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            sync_err_q  <= sync_err_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign sync_err  = sync_err_q;
    assign overflow  = overflow_q;
endmodule
